alu_op_issuer: RTL and testbench

Front end of the RISC-V ALU datapath. It accepts decoded R-type and I-type arithmetic/logic instruction fields over a valid/ready handshake and translates funct3/funct7 into the 4-bit ALU operation code. It drives operands and the operation code to the execution units (logical, arithmetic and shift), waits for completion, and returns result, zero flag and destination register over a second valid/ready handshake.

---
 rtl/alu_op_issuer.sv | 128 ++++++++++++
 tb/tb_alu_op_issuer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// RISC-V ALU front end: decodes R/I-type funct3/funct7 into an ALU op code, issues
// operands to the execution units and returns result/zero/rd with timeout and illegal-encoding errors.
module alu_op_issuer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_funct3,
   input  logic        in_funct7_5,
   input  logic        in_is_imm,
   input  logic [31:0] in_rs1_val,
   input  logic [31:0] in_rs2_val,
   input  logic [31:0] in_imm,
   input  logic [4:0]  in_rd,
   output logic [31:0] alu_A,
   output logic [31:0] alu_B,
   output logic [3:0]  alu_operation,
   output logic        alu_valid,
   input  logic        alu_done,
   input  logic [31:0] alu_Result,
   input  logic        alu_ZeroFlag,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_zero,
   output logic [4:0]  out_rd,
   output logic        out_error
);

   // state  | meaning
   // S_IDLE | waiting for an instruction
   // S_WAIT | request issued, waiting for alu_done or timeout
   // S_RESP | response presented until out_ready
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state, state_nxt;
   logic [7:0]  wait_cnt;
   logic        accept;
   logic        legal;
   logic        timeout_hit;
   logic [3:0]  op_dec;
   logic [31:0] b_dec;

   // in_ready is gated by rst so it reads 0 for the whole reset assertion
   assign in_ready    = (state == S_IDLE) & ~rst;
   assign alu_valid   = (state == S_WAIT);
   assign out_valid   = (state == S_RESP);
   assign accept      = in_valid & in_ready;
   assign timeout_hit = ((wait_cnt + 8'd1) == 8'(TIMEOUT_CYCLES));

   always_comb begin
      op_dec = 4'b0000;
      legal  = 1'b1;
      b_dec  = in_is_imm ? in_imm : in_rs2_val;
      case (in_funct3)
         3'b000: op_dec = (in_funct7_5 & ~in_is_imm) ? 4'b0001 : 4'b0000;
         3'b001: begin
            op_dec = 4'b0010;
            legal  = ~in_funct7_5;
         end
         3'b010: op_dec = 4'b0011;
         3'b011: op_dec = 4'b0100;
         3'b100: op_dec = 4'b1100;
         3'b101: op_dec = in_funct7_5 ? 4'b0110 : 4'b0101;
         3'b110: op_dec = 4'b1011;
         3'b111: op_dec = 4'b1010;
         default: op_dec = 4'b0000;
      endcase
      if (~in_is_imm & in_funct7_5 & (in_funct3 != 3'b000) & (in_funct3 != 3'b101))
         legal = 1'b0;
      // immediate shifts only use shamt; the upper bits carry the SRA selector
      if (in_is_imm & ((in_funct3 == 3'b001) | (in_funct3 == 3'b101)))
         b_dec = {27'b0, in_imm[4:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = legal ? S_WAIT : S_RESP;
         S_WAIT: if (alu_done | timeout_hit) state_nxt = S_RESP;
         S_RESP: if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_A         <= '0;
         alu_B         <= '0;
         alu_operation <= '0;
         out_result    <= '0;
         out_zero      <= 1'b0;
         out_rd        <= '0;
         out_error     <= 1'b0;
         wait_cnt      <= '0;
      end else begin
         if (accept) begin
            alu_A         <= in_rs1_val;
            alu_B         <= b_dec;
            alu_operation <= op_dec;
            out_rd        <= in_rd;
            out_result    <= '0;
            out_zero      <= 1'b0;
            out_error     <= ~legal;
            wait_cnt      <= '0;
         end
         if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
            // a completion on the terminal edge beats the timeout
            if (alu_done) begin
               out_result <= alu_Result;
               out_zero   <= alu_ZeroFlag;
               out_error  <= 1'b0;
            end else if (timeout_hit) begin
               out_error  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer: table vectors, random instructions against
// a behavioural model, and hand-written reset/backpressure sequences.
module tb_alu_op_issuer;
   localparam int TO = 16;

   logic        clk = 0, rst = 0;
   logic        in_valid = 0, in_ready;
   logic [2:0]  in_funct3 = 0;
   logic        in_funct7_5 = 0, in_is_imm = 0;
   logic [31:0] in_rs1_val = 0, in_rs2_val = 0, in_imm = 0;
   logic [4:0]  in_rd = 0;
   logic [31:0] alu_A, alu_B;
   logic [3:0]  alu_operation;
   logic        alu_valid;
   logic        alu_done = 0;
   logic [31:0] alu_Result = 0;
   logic        alu_ZeroFlag = 0;
   logic        out_valid;
   logic        out_ready = 0;
   logic [31:0] out_result;
   logic        out_zero;
   logic [4:0]  out_rd;
   logic        out_error;

   always #5 clk = ~clk;

   alu_op_issuer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_is_imm(in_is_imm),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_rd(in_rd),
      .alu_A(alu_A), .alu_B(alu_B), .alu_operation(alu_operation), .alu_valid(alu_valid),
      .alu_done(alu_done), .alu_Result(alu_Result), .alu_ZeroFlag(alu_ZeroFlag),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_rd(out_rd), .out_error(out_error)
   );

   typedef struct {
      logic [2:0]  f3;
      logic        f7;
      logic        isimm;
      logic [31:0] rs1, rs2, imm;
      logic [4:0]  rd;
      int          d;       // WAIT cycle index carrying alu_done; negative = never
      logic [31:0] res;
      logic        zf;
      int          rdly;    // cycles out_ready is held low
      logic [3:0]  exp_op;
      logic [31:0] exp_b;
      logic        exp_err;
   } vec_t;

   int n_cmp = 0, n_bad = 0;

   // opcode by funct3 before the funct7 variants (SUB, SRA)
   localparam logic [3:0] BASE_OP [8] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'hC, 4'h5, 4'hB, 4'hA};

   logic [3:0]  obs_op;
   logic [31:0] obs_a, obs_b, obs_res;
   logic        obs_zero, obs_err;
   logic [4:0]  obs_rd;
   int          obs_vcnt, obs_lat;
   logic        obs_hold_ok, obs_busy_ok, obs_release_ok, obs_bound_ok;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic model_legal(input logic [2:0] f3, input logic f7, input logic isimm);
      if (f7 && f3 == 3'd1) return 1'b0;
      if (f7 && !isimm && !(f3 == 3'd0 || f3 == 3'd5)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [3:0] model_op(input logic [2:0] f3, input logic f7, input logic isimm);
      logic [3:0] op;
      op = BASE_OP[f3];
      if (f3 == 3'd0 && f7 && !isimm) op = 4'h1;
      if (f3 == 3'd5 && f7) op = 4'h6;
      return op;
   endfunction

   function automatic logic [31:0] model_b(input vec_t v);
      if (!v.isimm) return v.rs2;
      if (v.f3 == 3'd1 || v.f3 == 3'd5) return v.imm % 32;
      return v.imm;
   endfunction

   function automatic vec_t mk(input logic [2:0] f3, input logic f7, input logic isimm,
                               input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                               input logic [4:0] rd, input int d, input logic [31:0] res, input logic zf,
                               input int rdly, input logic [3:0] eop, input logic [31:0] eb, input logic eerr);
      vec_t v;
      v.f3 = f3; v.f7 = f7; v.isimm = isimm; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.rd = rd;
      v.d = d; v.res = res; v.zf = zf; v.rdly = rdly; v.exp_op = eop; v.exp_b = eb; v.exp_err = eerr;
      return v;
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic run_op(input vec_t v);
      int  guard;
      logic seen;
      obs_vcnt = 0; obs_lat = 0; seen = 0;
      obs_hold_ok = 1; obs_busy_ok = 1; obs_bound_ok = 1; obs_release_ok = 0;
      obs_op = 'x; obs_a = 'x; obs_b = 'x;
      guard = 0;
      while (!in_ready && guard < 20) begin step(); guard++; end
      if (!in_ready) obs_bound_ok = 0;
      in_valid = 1; in_funct3 = v.f3; in_funct7_5 = v.f7; in_is_imm = v.isimm;
      in_rs1_val = v.rs1; in_rs2_val = v.rs2; in_imm = v.imm; in_rd = v.rd;
      alu_done = 1; alu_Result = 32'hDEAD_BEEF; alu_ZeroFlag = 1;   // ignored in IDLE
      step();
      in_valid = 0; in_funct3 = 3'($urandom); in_funct7_5 = 1'($urandom); in_is_imm = 1'($urandom);
      in_rs1_val = $urandom; in_rs2_val = $urandom; in_imm = $urandom; in_rd = 5'($urandom);
      obs_lat = 1;
      while (!out_valid && obs_lat < 40) begin
         if (alu_valid) begin
            if (!seen) begin
               obs_op = alu_operation; obs_a = alu_A; obs_b = alu_B; seen = 1;
            end else if (alu_operation !== obs_op || alu_A !== obs_a || alu_B !== obs_b) obs_hold_ok = 0;
            alu_done = (obs_vcnt == v.d); alu_Result = v.res; alu_ZeroFlag = v.zf;
            obs_vcnt++;
         end else alu_done = 0;
         step();
         obs_lat++;
      end
      if (!out_valid) obs_bound_ok = 0;
      if (alu_valid) obs_hold_ok = 0;
      alu_done = 1; alu_Result = 32'h1234_5678; alu_ZeroFlag = ~v.zf;   // ignored in RESP
      obs_res = out_result; obs_zero = out_zero; obs_rd = out_rd; obs_err = out_error;
      out_ready = 0;
      for (int i = 0; i < v.rdly; i++) begin
         if (in_ready !== 1'b0) obs_busy_ok = 0;
         step();
         if (out_valid !== 1'b1 || out_result !== obs_res || out_zero !== obs_zero ||
             out_rd !== obs_rd || out_error !== obs_err) obs_hold_ok = 0;
      end
      if (in_ready !== 1'b0) obs_busy_ok = 0;
      out_ready = 1;
      step();
      out_ready = 0; alu_done = 0;
      obs_release_ok = (in_ready === 1'b1) && (out_valid === 1'b0);
   endtask

   task automatic check_run(input string tag, input vec_t v);
      logic lg;
      int   e_lat, e_vcnt;
      logic e_err;
      lg = model_legal(v.f3, v.f7, v.isimm);
      if (!lg) begin
         e_lat = 1; e_vcnt = 0; e_err = 1;
      end else if (v.d >= 0 && v.d < TO) begin
         e_lat = v.d + 2; e_vcnt = v.d + 1; e_err = 0;
      end else begin
         e_lat = TO + 1; e_vcnt = TO; e_err = 1;
      end
      check({tag, " bound"}, 32'(obs_bound_ok), 1);
      if (lg) begin
         check({tag, " alu_A"}, obs_a, v.rs1);
         check({tag, " alu_op"}, 32'(obs_op), 32'(model_op(v.f3, v.f7, v.isimm)));
         check({tag, " alu_B"}, obs_b, model_b(v));
      end
      check({tag, " valid_cycles"}, obs_vcnt, e_vcnt);
      check({tag, " latency"}, obs_lat, e_lat);
      check({tag, " result"}, obs_res, e_err ? 32'd0 : v.res);
      check({tag, " zero"}, 32'(obs_zero), e_err ? 32'd0 : 32'(v.zf));
      check({tag, " rd"}, 32'(obs_rd), 32'(v.rd));
      check({tag, " error"}, 32'(obs_err), 32'(e_err));
      check({tag, " hold"}, 32'(obs_hold_ok), 1);
      check({tag, " busy"}, 32'(obs_busy_ok), 1);
      check({tag, " release"}, 32'(obs_release_ok), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      vec_t vecs [12];
      vec_t v;
      vecs[0]  = mk(3'd7, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 5'd5, 1, 32'h00F0_00F0, 0, 0, 4'hA, 32'h0FF0_0FF0, 0);
      vecs[1]  = mk(3'd5, 1, 1, 32'h8000_0000, 32'h1234_5678, 32'h0000_0403, 5'd7, 0, 32'hF000_0000, 0, 1, 4'h6, 32'h3, 0);
      vecs[2]  = mk(3'd0, 1, 1, 32'h5, 32'hAAAA, 32'hFFFF_F800, 5'd1, 2, 32'hFFFF_F805, 0, 0, 4'h0, 32'hFFFF_F800, 0);
      vecs[3]  = mk(3'd6, 1, 0, 32'h1, 32'h2, 0, 5'd9, 0, 32'h3, 0, 2, 4'h0, 32'h0, 1);
      vecs[4]  = mk(3'd4, 0, 0, 32'h11, 32'h22, 0, 5'd12, -1, 32'h33, 0, 0, 4'hC, 32'h22, 1);
      vecs[5]  = mk(3'd4, 0, 0, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 0, 5'd3, 0, 32'h0, 1, 5, 4'hC, 32'h5A5A_5A5A, 0);
      vecs[6]  = mk(3'd0, 1, 0, 32'h10, 32'h10, 0, 5'd31, 3, 32'h0, 1, 0, 4'h1, 32'h10, 0);
      vecs[7]  = mk(3'd1, 1, 1, 32'h1, 32'h2, 32'h0000_0405, 5'd2, 0, 32'h4, 0, 0, 4'h0, 32'h0, 1);
      vecs[8]  = mk(3'd1, 0, 1, 32'h1, 32'h2, 32'hFFFF_FFE5, 5'd4, TO - 1, 32'h20, 0, 1, 4'h2, 32'h5, 0);
      vecs[9]  = mk(3'd2, 0, 0, 32'h7, 32'h9, 0, 5'd6, TO, 32'h1, 0, 0, 4'h3, 32'h9, 1);
      vecs[10] = mk(3'd3, 0, 1, 32'h7FF, 32'h0, 32'h0000_0800, 5'd8, 0, 32'h1, 0, 0, 4'h4, 32'h800, 0);
      vecs[11] = mk(3'd5, 0, 0, 32'hF000_0000, 32'h4, 0, 5'd10, 1, 32'h0F00_0000, 0, 3, 4'h5, 32'h4, 0);

      #1 rst = 1;
      #2;
      check("rst in_ready", 32'(in_ready), 0);
      check("rst alu_valid", 32'(alu_valid), 0);
      check("rst alu_A", alu_A, 0);
      check("rst alu_B", alu_B, 0);
      check("rst alu_op", 32'(alu_operation), 0);
      check("rst out_valid", 32'(out_valid), 0);
      check("rst out_result", out_result, 0);
      check("rst out_zero", 32'(out_zero), 0);
      check("rst out_rd", 32'(out_rd), 0);
      check("rst out_error", 32'(out_error), 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      step();
      check("release in_ready", 32'(in_ready), 1);

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i]);
         check_run($sformatf("vec%0d", i), vecs[i]);
         if (model_legal(vecs[i].f3, vecs[i].f7, vecs[i].isimm)) begin
            check($sformatf("vec%0d table_op", i), 32'(obs_op), 32'(vecs[i].exp_op));
            check($sformatf("vec%0d table_B", i), obs_b, vecs[i].exp_b);
         end
         check($sformatf("vec%0d table_err", i), 32'(obs_err), 32'(vecs[i].exp_err));
      end

      for (int i = 0; i < 30; i++) begin
         v.f3 = 3'($urandom_range(0, 7));
         v.f7 = ($urandom_range(0, 3) == 0);
         v.isimm = 1'($urandom_range(0, 1));
         v.rs1 = $urandom; v.rs2 = $urandom; v.imm = $urandom;
         v.rd = 5'($urandom);
         v.d = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
         v.res = $urandom; v.zf = 1'($urandom);
         v.rdly = int'($urandom_range(0, 2));
         run_op(v);
         check_run($sformatf("rand%0d", i), v);
      end

      // reset while a request is outstanding
      while (!in_ready) step();
      in_valid = 1; in_funct3 = 3'd0; in_funct7_5 = 1; in_is_imm = 0;
      in_rs1_val = 32'h100; in_rs2_val = 32'h1; in_rd = 5'd11;
      step();
      in_valid = 0; alu_done = 0;
      step(); step();
      check("mid alu_valid before rst", 32'(alu_valid), 1);
      #2 rst = 1;
      #1;
      check("mid alu_valid", 32'(alu_valid), 0);
      check("mid out_valid", 32'(out_valid), 0);
      check("mid in_ready", 32'(in_ready), 0);
      check("mid alu_A", alu_A, 0);
      step();
      rst = 0;
      step();
      check("mid no response", 32'(out_valid), 0);
      check("mid in_ready after", 32'(in_ready), 1);
      v = mk(3'd5, 1, 0, 32'h8000_0000, 32'h4, 0, 5'd13, 0, 32'hF800_0000, 0, 0, 4'h6, 32'h4, 0);
      run_op(v);
      check_run("post_rst", v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
